// File: rtl/river_pkg.sv
`default_nettype none
// ============================================================================
// Module   : river_pkg
// Purpose  : Shared definitions for the river-crossing game engine: FSM state
//            encoding, default cargo item indices and the default predator/prey
//            matrix (fox eats goat, goat eats beans).
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package river_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CROSS = 3'd1,
    ST_CHECK = 3'd2,
    ST_WON   = 3'd3,
    ST_LOST  = 3'd4
  } state_t;

  localparam int FOX   = 0;
  localparam int GOAT  = 1;
  localparam int BEANS = 2;

  localparam int DEFAULT_N_ITEMS = 3;

  // bit[i*N+j] set means item i eats item j
  localparam logic [8:0] DEFAULT_EAT_MASK = (9'd1 << (FOX * DEFAULT_N_ITEMS + GOAT)) |
                                            (9'd1 << (GOAT * DEFAULT_N_ITEMS + BEANS));

endpackage
`default_nettype wire

// File: rtl/river_eat_check.sv
`default_nettype none
// ============================================================================
// Module   : river_eat_check
// Purpose  : Combinational predator/prey evaluator. A prey item is eaten when
//            some predator that may eat it shares its bank and the farmer is
//            on the other bank. Diagonal (self-eating) matrix bits are ignored.
// Ports    : item_pos   in  N_ITEMS  bank of each cargo item
//            farmer_pos in  1        bank of the farmer
//            eaten_mask out N_ITEMS  one bit per prey item currently eaten
// Revision : 1.0 - initial release
// ============================================================================
module river_eat_check
  import river_pkg::*;
#(
  parameter int                         N_ITEMS  = DEFAULT_N_ITEMS,
  parameter logic [N_ITEMS*N_ITEMS-1:0] EAT_MASK = (N_ITEMS*N_ITEMS)'(DEFAULT_EAT_MASK)
) (
  input  logic [N_ITEMS-1:0] item_pos,
  input  logic               farmer_pos,
  output logic [N_ITEMS-1:0] eaten_mask
);

  // hit[j*N+i]: predator i is eating prey j right now (grouped by prey so
  // each prey reduces over a contiguous slice)
  logic [N_ITEMS*N_ITEMS-1:0] hit;

  for (genvar j = 0; j < N_ITEMS; j++) begin : g_prey
    for (genvar i = 0; i < N_ITEMS; i++) begin : g_pred
      if (i == j) begin : g_self
        assign hit[j*N_ITEMS+i] = 1'b0;
      end else begin : g_pair
        assign hit[j*N_ITEMS+i] = EAT_MASK[i*N_ITEMS+j] &&
                                  (item_pos[i] == item_pos[j]) &&
                                  (item_pos[j] != farmer_pos);
      end
    end
    assign eaten_mask[j] = |hit[j*N_ITEMS +: N_ITEMS];
  end

endmodule
`default_nettype wire

// File: rtl/river_crossing_engine.sv
`default_nettype none
// ============================================================================
// Module   : river_crossing_engine
// Purpose  : Sequential river-crossing puzzle engine (farmer + N_ITEMS items).
//            Accepts move commands via valid/ready, models a timed crossing,
//            then evaluates the predator/prey matrix and reports the outcome.
// Ports    : clk, reset_n (async, active-low), restart (sync, over cmd)
//            cmd_valid/cmd_ready/cmd_cargo  move command handshake
//            farmer_pos, item_pos           banks (0 = start, 1 = far)
//            busy                           crossing in progress
//            move_err                       1-cycle pulse on rejected command
//            eaten, eaten_mask, won, lost   sticky outcome flags
//            move_count                     accepted moves, saturating
// Revision : 1.0 - initial release
// ============================================================================
module river_crossing_engine
  import river_pkg::*;
#(
  parameter int                         N_ITEMS      = DEFAULT_N_ITEMS,
  parameter int                         BOAT_CAP     = 1,
  parameter int                         CROSS_CYCLES = 4,
  parameter int                         MOVE_LIMIT   = 15,
  parameter logic [N_ITEMS*N_ITEMS-1:0] EAT_MASK     = (N_ITEMS*N_ITEMS)'(DEFAULT_EAT_MASK)
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              restart,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic [N_ITEMS-1:0]                cmd_cargo,
  output logic                              farmer_pos,
  output logic [N_ITEMS-1:0]                item_pos,
  output logic                              busy,
  output logic                              move_err,
  output logic                              eaten,
  output logic [N_ITEMS-1:0]                eaten_mask,
  output logic                              won,
  output logic                              lost,
  output logic [$clog2(MOVE_LIMIT+1)-1:0]   move_count
);

  localparam int                MC_W     = $clog2(MOVE_LIMIT + 1);
  localparam int                CNT_W    = (CROSS_CYCLES > 1) ? $clog2(CROSS_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(CROSS_CYCLES - 1);
  localparam logic [MC_W-1:0]   MC_MAX   = MC_W'(MOVE_LIMIT);

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   cross_cnt;
  logic [N_ITEMS-1:0] cargo_q;
  logic [31:0]        cargo_pop;
  logic               legal;
  logic               accept;
  logic               cross_done;
  logic               all_far;
  logic [N_ITEMS-1:0] eat_now;

  river_eat_check #(
    .N_ITEMS  (N_ITEMS),
    .EAT_MASK (EAT_MASK)
  ) u_eat_check (
    .item_pos   (item_pos),
    .farmer_pos (farmer_pos),
    .eaten_mask (eat_now)
  );

  always_comb begin
    cargo_pop = '0;
    for (int k = 0; k < N_ITEMS; k++) begin
      cargo_pop = cargo_pop + 32'(cmd_cargo[k]);
    end
  end

  // Every selected item must sit on the farmer's bank to board the boat.
  assign legal      = (cargo_pop <= 32'(BOAT_CAP)) &&
                      ((cmd_cargo & (item_pos ^ {N_ITEMS{farmer_pos}})) == '0);
  assign accept     = (state == ST_IDLE) && cmd_valid && legal;
  assign cross_done = (state == ST_CROSS) && (cross_cnt == '0);
  assign all_far    = farmer_pos && (&item_pos);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; restart wins over everything including terminal states
  always_comb begin
    state_next = state;
    if (restart) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (accept) state_next = ST_CROSS;
        ST_CROSS: if (cross_done) state_next = ST_CHECK;
        ST_CHECK: begin
          // eaten beats win; win beats the move limit
          if (|eat_now)                  state_next = ST_LOST;
          else if (all_far)              state_next = ST_WON;
          else if (move_count == MC_MAX) state_next = ST_LOST;
          else                           state_next = ST_IDLE;
        end
        ST_WON:   state_next = ST_WON;
        ST_LOST:  state_next = ST_LOST;
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  // State-decoded outputs
  always_comb begin
    cmd_ready = (state == ST_IDLE);
    busy      = (state == ST_CROSS);
  end

  // Datapath: positions, counters and sticky outcome flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      farmer_pos <= 1'b0;
      item_pos   <= '0;
      cargo_q    <= '0;
      cross_cnt  <= '0;
      move_count <= '0;
      move_err   <= 1'b0;
      eaten      <= 1'b0;
      eaten_mask <= '0;
      won        <= 1'b0;
      lost       <= 1'b0;
    end else if (restart) begin
      farmer_pos <= 1'b0;
      item_pos   <= '0;
      cargo_q    <= '0;
      cross_cnt  <= '0;
      move_count <= '0;
      move_err   <= 1'b0;
      eaten      <= 1'b0;
      eaten_mask <= '0;
      won        <= 1'b0;
      lost       <= 1'b0;
    end else begin
      move_err <= (state == ST_IDLE) && cmd_valid && !legal;

      if (accept) begin
        cargo_q   <= cmd_cargo;
        cross_cnt <= CNT_LOAD;
        if (move_count != MC_MAX) begin
          move_count <= move_count + MC_W'(1);
        end
      end

      if (state == ST_CROSS) begin
        if (cross_done) begin
          farmer_pos <= ~farmer_pos;
          item_pos   <= item_pos ^ cargo_q;
        end else begin
          cross_cnt <= cross_cnt - CNT_W'(1);
        end
      end

      if (state == ST_CHECK) begin
        if (|eat_now) begin
          eaten      <= 1'b1;
          eaten_mask <= eat_now;
          lost       <= 1'b1;
        end else if (all_far) begin
          won <= 1'b1;
        end else if (move_count == MC_MAX) begin
          lost <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_river_crossing_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_river_crossing_engine
// Purpose  : Self-checking bench. Two engines share one command stream: A uses
//            the default classic puzzle, B a 4-item, 2-seat, 1-cycle, 3-move
//            variant with a custom predator matrix. A timeline reference model
//            predicts each engine's outputs every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_river_crossing_engine;

  localparam int          NA = 3, CAPA = 1, CCA = 4, MLA = 15;
  localparam int          NB = 4, CAPB = 2, CCB = 1, MLB = 3;
  // 0 eats 1, 2 eats 3, 3 eats 0, plus a diagonal bit (1 eats 1) to ignore
  localparam logic [15:0] MASKB = 16'h1822;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       restart = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [3:0] cmd_cargo = 4'd0;

  logic       a_ready, a_fpos, a_busy, a_err, a_eaten, a_won, a_lost;
  logic [2:0] a_ipos, a_emask;
  logic [3:0] a_mc;
  logic       b_ready, b_fpos, b_busy, b_err, b_eaten, b_won, b_lost;
  logic [3:0] b_ipos, b_emask;
  logic [1:0] b_mc;

  always #5 clk = ~clk;

  river_crossing_engine #(
    .N_ITEMS(NA), .BOAT_CAP(CAPA), .CROSS_CYCLES(CCA), .MOVE_LIMIT(MLA)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .restart(restart), .cmd_valid(cmd_valid),
    .cmd_ready(a_ready), .cmd_cargo(cmd_cargo[2:0]), .farmer_pos(a_fpos),
    .item_pos(a_ipos), .busy(a_busy), .move_err(a_err), .eaten(a_eaten),
    .eaten_mask(a_emask), .won(a_won), .lost(a_lost), .move_count(a_mc)
  );

  river_crossing_engine #(
    .N_ITEMS(NB), .BOAT_CAP(CAPB), .CROSS_CYCLES(CCB), .MOVE_LIMIT(MLB),
    .EAT_MASK(MASKB)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .restart(restart), .cmd_valid(cmd_valid),
    .cmd_ready(b_ready), .cmd_cargo(cmd_cargo), .farmer_pos(b_fpos),
    .item_pos(b_ipos), .busy(b_busy), .move_err(b_err), .eaten(b_eaten),
    .eaten_mask(b_emask), .won(b_won), .lost(b_lost), .move_count(b_mc)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model (per engine k: 0 = A, 1 = B) ----------
  int          n    [2] = '{NA, NB};
  int          cap  [2] = '{CAPA, CAPB};
  int          cc   [2] = '{CCA, CCB};
  int          ml   [2] = '{MLA, MLB};
  logic [15:0] mask [2] = '{16'h0022, MASKB};

  logic       m_fp [2];
  logic [3:0] m_ip [2];
  int         m_mc [2];
  logic       m_eat[2], m_won[2], m_lost[2], m_err[2], m_pend[2];
  logic [3:0] m_em [2];
  int         m_tacc[2];
  logic [3:0] m_cargo[2];
  logic [3:0] o_em [2];
  logic       o_win[2], o_lim[2];
  int         edge_no = 0;

  function automatic logic [3:0] prey_eaten(input int k, input logic fp, input logic [3:0] ip);
    logic [3:0] r = 4'd0;
    for (int j = 0; j < n[k]; j++)
      for (int i = 0; i < n[k]; i++)
        if (i != j && mask[k][i*n[k]+j] && ip[i] == ip[j] && ip[j] != fp) r[j] = 1'b1;
    return r;
  endfunction

  task automatic model_clear(input int k);
    m_fp[k] = 0; m_ip[k] = 0; m_mc[k] = 0; m_eat[k] = 0; m_won[k] = 0;
    m_lost[k] = 0; m_err[k] = 0; m_pend[k] = 0; m_em[k] = 0; m_tacc[k] = 0;
    m_cargo[k] = 0; o_em[k] = 0; o_win[k] = 0; o_lim[k] = 0;
  endtask

  // What each engine shows after the next rising edge, given these inputs.
  task automatic model_edge(input logic v, input logic [3:0] cargo, input logic rs);
    logic [3:0] c, nip, full;
    logic       ok;
    edge_no++;
    for (int k = 0; k < 2; k++) begin
      full = 4'((1 << n[k]) - 1);
      if (rs) begin
        model_clear(k);
      end else begin
        m_err[k] = 0;
        if (m_pend[k]) begin
          if (edge_no == m_tacc[k] + cc[k]) begin
            m_fp[k] = ~m_fp[k];
            m_ip[k] = m_ip[k] ^ m_cargo[k];
          end
          if (edge_no == m_tacc[k] + cc[k] + 1) begin
            m_pend[k] = 0;
            if (o_em[k] != 0) begin
              m_eat[k] = 1; m_em[k] = o_em[k]; m_lost[k] = 1;
            end else if (o_win[k]) m_won[k] = 1;
            else if (o_lim[k]) m_lost[k] = 1;
          end
        end else if (!m_won[k] && !m_lost[k] && v) begin
          c  = cargo & full;
          ok = ($countones(c) <= cap[k]);
          for (int i = 0; i < n[k]; i++) if (c[i] && m_ip[k][i] != m_fp[k]) ok = 0;
          if (ok) begin
            m_pend[k]  = 1;
            m_tacc[k]  = edge_no;
            m_cargo[k] = c;
            if (m_mc[k] < ml[k]) m_mc[k]++;
            nip      = m_ip[k] ^ c;
            o_em[k]  = prey_eaten(k, ~m_fp[k], nip);
            o_win[k] = ~m_fp[k] && (nip == full);
            o_lim[k] = (m_mc[k] == ml[k]);
          end else begin
            m_err[k] = 1;
          end
        end
      end
    end
  endtask

  function automatic logic [31:0] exp_pack(input int k);
    logic rdy = !m_pend[k] && !m_won[k] && !m_lost[k];
    logic bsy = m_pend[k] && (edge_no < m_tacc[k] + cc[k]);
    return {13'd0, rdy, bsy, m_err[k], m_fp[k], m_ip[k], m_eat[k], m_em[k],
            m_won[k], m_lost[k], 4'(m_mc[k])};
  endfunction

  function automatic logic [31:0] obs_a();
    return {13'd0, a_ready, a_busy, a_err, a_fpos, 1'b0, a_ipos, a_eaten, 1'b0, a_emask,
            a_won, a_lost, a_mc};
  endfunction

  function automatic logic [31:0] obs_b();
    return {13'd0, b_ready, b_busy, b_err, b_fpos, b_ipos, b_eaten, b_emask,
            b_won, b_lost, 2'd0, b_mc};
  endfunction

  // One clock: drive at negedge, predict, sample 1 time unit after posedge.
  task automatic step(input logic v, input logic [3:0] cargo, input logic rs);
    @(negedge clk);
    cmd_valid = v; cmd_cargo = cargo; restart = rs;
    model_edge(v, cargo, rs);
    @(posedge clk);
    #1;
    check_eq("cycle_A", obs_a(), exp_pack(0));
    check_eq("cycle_B", obs_b(), exp_pack(1));
  endtask

  // Offer one move, then idle until engine k has finished evaluating it.
  task automatic play(input int k, input logic [3:0] cargo);
    int guard = 0;
    step(1'b1, cargo, 1'b0);
    while (m_pend[k] && guard < 20) begin
      step(1'b0, 4'd0, 1'b0);
      guard++;
    end
    check_eq("play_timeout", 32'(m_pend[k]), 32'd0);
  endtask

  logic [3:0] classic [7] = '{4'b010, 4'b000, 4'b001, 4'b010, 4'b100, 4'b000, 4'b010};

  initial begin
    model_clear(0);
    model_clear(1);
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_A", obs_a(), 32'(1) << 18);
    check_eq("reset_B", obs_b(), 32'(1) << 18);
    @(negedge clk);
    reset_n = 1'b1;

    // Classic solution on A
    step(1'b0, 4'd0, 1'b1);
    for (int s = 0; s < 7; s++) play(0, classic[s]);
    check_eq("t1_won", 32'(a_won), 32'd1);
    check_eq("t1_mc", 32'(a_mc), 32'd7);
    check_eq("t1_ipos", 32'(a_ipos), 32'b111);
    check_eq("t1_fpos", 32'(a_fpos), 32'd1);

    // Fox first: goat eats beans
    step(1'b0, 4'd0, 1'b1);
    play(0, 4'b001);
    check_eq("t2_eaten", 32'(a_eaten), 32'd1);
    check_eq("t2_mask", 32'(a_emask), 32'b100);
    check_eq("t2_lost", 32'(a_lost), 32'd1);
    step(1'b1, 4'b010, 1'b0);
    check_eq("t2_ignored", 32'({a_ipos, a_mc, a_err}), 32'({3'b001, 4'd1, 1'b0}));

    // Capacity and wrong-bank rejections
    step(1'b0, 4'd0, 1'b1);
    step(1'b1, 4'b011, 1'b0);
    check_eq("t3_cap_err", 32'(a_err), 32'd1);
    play(0, 4'b010);
    step(1'b1, 4'b001, 1'b0);
    check_eq("t3_bank_err", 32'(a_err), 32'd1);
    check_eq("t3_ipos", 32'(a_ipos), 32'b010);
    step(1'b0, 4'd0, 1'b0);
    check_eq("t3_err_pulse", 32'(a_err), 32'd0);

    // Async reset two cycles into a crossing
    step(1'b0, 4'd0, 1'b1);
    step(1'b1, 4'b010, 1'b0);
    step(1'b0, 4'd0, 1'b0);
    step(1'b0, 4'd0, 1'b0);
    @(negedge clk);
    cmd_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check_eq("t4_abort", 32'({a_fpos, a_ipos, a_busy, a_ready}), 32'({1'b0, 3'b000, 1'b0, 1'b1}));
    model_clear(0);
    model_clear(1);
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b0, 4'd0, 1'b0);
    check_eq("t4_ready", 32'(a_ready), 32'd1);

    // Move limit on B (also exercises the ignored diagonal bit)
    step(1'b0, 4'd0, 1'b1);
    play(1, 4'b0101);
    play(1, 4'b0000);
    play(1, 4'b0000);
    check_eq("t5_flags", 32'({b_lost, b_eaten, b_won, b_mc}), 32'({1'b1, 1'b0, 1'b0, 2'd3}));
    step(1'b0, 4'd0, 1'b1);
    check_eq("t5_restart", 32'({b_lost, b_eaten, b_won, b_mc, b_ready}), 32'({3'b000, 2'd0, 1'b1}));

    // Cycle-exact custom matrix on B
    step(1'b1, 4'b0010, 1'b0);
    check_eq("t6_busy", 32'(b_busy), 32'd1);
    step(1'b0, 4'd0, 1'b0);
    check_eq("t6_pos", 32'({b_fpos, b_ipos, b_lost}), 32'({1'b1, 4'b0010, 1'b0}));
    step(1'b0, 4'd0, 1'b0);
    check_eq("t6_flags", 32'({b_eaten, b_emask, b_lost}), 32'({1'b1, 4'b1001, 1'b1}));

    // Randomised play against the model
    step(1'b0, 4'd0, 1'b1);
    for (int r = 0; r < 3000; r++) begin
      step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
           ($urandom_range(0, 63) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
